// File: rtl/rv_pkg.sv
// Purpose: shared widths and the write-back entry type for the integer register file.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package rv_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  // One pending register write: destination and value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // One-hot mask selecting register r.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_AW-1:0] r);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Purpose: synchronous FIFO of write-back entries with occupancy count.
// Latency: a push is visible at the head on the next cycle; no bypass.
// Backpressure: pushes while full and pops while empty are ignored; the caller gates them.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_dat,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  wb_entry_t   mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign count   = wptr - rptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wptr == rptr);
  assign head    = mem[rptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; reset drops everything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: slots are only read once written behind wptr.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Purpose: merges ALU results and load returns into one register-file write per cycle, plus a pending-load scoreboard.
// Latency: ALU result writes next cycle; load return writes two cycles after acceptance at the earliest.
// Backpressure: ld_ready/alu_stall follow the registered FIFO-full state only; a full FIFO drains before ALU traffic.
module regfile_writeback #(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int REG_AW = rv_pkg::REG_AW,
  parameter int DEPTH  = 4,
  localparam int NREGS = 2 ** REG_AW,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_stall,
  input  logic              ld_issue,
  input  logic [REG_AW-1:0] ld_issue_rd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic [NREGS-1:0]  busy,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_addr,
  output logic [XLEN-1:0]   rf_data,
  output logic [CW-1:0]     fifo_count
);

  import rv_pkg::*;

  wb_entry_t        push_dat;
  wb_entry_t        head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             alu_sel;
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;

  // Flow control depends only on the registered occupancy, never on inputs.
  assign ld_ready  = !fifo_full;
  assign alu_stall = fifo_full;

  // Loads to x0 are acknowledged but never queued.
  assign push          = ld_valid && !fifo_full && (ld_rd != '0);
  assign push_dat.rd   = ld_rd;
  assign push_dat.data = ld_data;

  // A full FIFO always wins so it can make room; otherwise ALU results go first.
  assign alu_sel = !fifo_full && alu_valid && (alu_rd != '0);
  assign pop     = fifo_full || (!alu_sel && !fifo_empty);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Register the selected write; address and data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      rf_we <= alu_sel || pop;
      if (alu_sel) begin
        rf_addr <= alu_rd;
        rf_data <= alu_data;
      end else if (pop) begin
        rf_addr <= head.rd;
        rf_data <= head.data;
      end
    end
  end

  // Scoreboard next state: pop clears, issue sets afterwards so set wins; x0 is never busy.
  always_comb begin
    busy_nxt = busy_q;
    if (pop) busy_nxt[head.rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != '0)) busy_nxt[ld_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register; the clear lands in the same cycle rf_we carries the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [31:0] busy;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  regfile_writeback #(.XLEN(32), .REG_AW(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .busy(busy), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: queue of pending loads, a busy bit per register, expected write port.
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic model_reset();
    m_q.delete();
    m_busy = '0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  // Advance model and DUT by one clock; called #1 after a rising edge with inputs set.
  task automatic tick();
    ent_t e;
    bit   full;
    full = (m_q.size() == DEPTH);
    if (!full && alu_valid && alu_rd != 0) begin
      m_we = 1; m_addr = alu_rd; m_data = alu_data;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = 1; m_addr = e.rd; m_data = e.data;
      m_busy[e.rd] = 1'b0;
    end else begin
      m_we = 0;
    end
    if (ld_issue && ld_issue_rd != 0) m_busy[ld_issue_rd] = 1'b1;
    if (ld_valid && !full && ld_rd != 0) m_q.push_back(ent_t'{ld_rd, ld_data});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_we); end
    checks++; if (rf_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rf_addr); end
    checks++; if (rf_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", rf_data); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (ld_ready !== 1'b1 || alu_stall !== 1'b0) begin errors++; $display("FAIL reset_flow: got ready=%b stall=%b want 1/0", ld_ready, alu_stall); end
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    idle();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'h1234) begin errors++; $display("FAIL alu_write: got we=%b addr=%0d data=%h want 1/5/1234", rf_we, rf_addr, rf_data); end
    idle();
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_idle_we: got %b want 0", rf_we); end
    checks++; if (rf_addr !== 5'd5 || rf_data !== 32'h1234) begin errors++; $display("FAIL alu_hold: got addr=%0d data=%h want 5/1234", rf_addr, rf_data); end
  endtask

  task automatic test_load();
    idle();
    ld_issue = 1; ld_issue_rd = 7;
    tick();
    checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL load_busy_set: got %b want 1", busy[7]); end
    idle();
    ld_valid = 1; ld_rd = 7; ld_data = 32'hCAFE;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", ld_ready); end
    tick();
    idle();
    checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd1) begin errors++; $display("FAIL load_no_bypass: got we=%b count=%0d want 0/1", rf_we, fifo_count); end
    checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL load_busy_hold: got %b want 1", busy[7]); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_data !== 32'hCAFE) begin errors++; $display("FAIL load_write: got we=%b addr=%0d data=%h want 1/7/cafe", rf_we, rf_addr, rf_data); end
    checks++; if (busy[7] !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL load_busy_clear: got busy7=%b count=%0d want 0/0", busy[7], fifo_count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 9; alu_data = 32'd100 + i;
      ld_valid = 1; ld_rd = 5'(10 + i); ld_data = 32'hD000 + i;
      ld_issue = 0;
      tick();
      checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd9 || rf_data !== 32'd100 + i) begin errors++; $display("FAIL fill_alu%0d: got we=%b addr=%0d data=%h", i, rf_we, rf_addr, rf_data); end
    end
    ld_valid = 0;
    checks++; if (fifo_count !== 3'd4 || ld_ready !== 1'b0 || alu_stall !== 1'b1) begin errors++; $display("FAIL fill_full: got count=%0d ready=%b stall=%b want 4/0/1", fifo_count, ld_ready, alu_stall); end
    alu_data = 32'd200;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd10 || rf_data !== 32'hD000) begin errors++; $display("FAIL fill_drain0: got addr=%0d data=%h want 10/d000", rf_addr, rf_data); end
    idle();
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++; if (rf_we !== 1'b1 || rf_addr !== 5'(10 + i) || rf_data !== 32'hD000 + i) begin errors++; $display("FAIL fill_drain%0d: got addr=%0d data=%h", i, rf_addr, rf_data); end
    end
    alu_valid = 1; alu_rd = 9; alu_data = 32'd300;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd9 || rf_data !== 32'd300) begin errors++; $display("FAIL fill_resume: got addr=%0d data=%h want 9/12c", rf_addr, rf_data); end
    idle();
    tick();
  endtask

  task automatic test_x0();
    idle();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
    ld_valid = 1; ld_rd = 0; ld_data = 32'hBEEF;
    ld_issue = 1; ld_issue_rd = 0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL x0_ack%0d: got ready=%b want 1", i, ld_ready); end
      tick();
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0 || busy !== m_busy) begin errors++; $display("FAIL x0_nowrite%0d: got we=%b count=%0d busy=%h", i, rf_we, fifo_count, busy); end
    end
    idle();
  endtask

  task automatic test_set_wins();
    idle();
    ld_issue = 1; ld_issue_rd = 3;
    tick();
    idle();
    ld_valid = 1; ld_rd = 3; ld_data = 32'h33;
    tick();
    idle();
    ld_issue = 1; ld_issue_rd = 3;
    tick();
    idle();
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'h33) begin errors++; $display("FAIL setwins_write: got we=%b addr=%0d data=%h", rf_we, rf_addr, rf_data); end
    checks++; if (busy[3] !== 1'b1) begin errors++; $display("FAIL setwins_busy: got %b want 1", busy[3]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      alu_valid   = ($urandom_range(0, 99) < 45);
      alu_rd      = 5'($urandom_range(0, 31));
      alu_data    = $urandom;
      ld_issue    = ($urandom_range(0, 99) < 30);
      ld_issue_rd = 5'($urandom_range(0, 31));
      ld_valid    = ($urandom_range(0, 99) < 50);
      ld_rd       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld_data     = $urandom;
      checks++; if (ld_ready !== (m_q.size() != DEPTH) || alu_stall !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rand_flow@%0d: got ready=%b stall=%b size=%0d", n, ld_ready, alu_stall, m_q.size()); end
      tick();
      checks++; if (rf_we !== m_we || rf_addr !== m_addr || rf_data !== m_data) begin errors++; $display("FAIL rand_write@%0d: got %b/%0d/%h want %b/%0d/%h", n, rf_we, rf_addr, rf_data, m_we, m_addr, m_data); end
      checks++; if (busy !== m_busy || fifo_count !== 3'(m_q.size())) begin errors++; $display("FAIL rand_state@%0d: got busy=%h count=%0d want %h/%0d", n, busy, fifo_count, m_busy, m_q.size()); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 1; alu_data = 32'h10 + i;
      ld_issue = 1; ld_issue_rd = 5'(4 + i);
      ld_valid = 1; ld_rd = 5'(4 + i); ld_data = 32'hA0 + i;
      tick();
    end
    checks++; if (fifo_count !== 3'd3 || busy[6:4] !== 3'b111) begin errors++; $display("FAIL rstmid_pre: got count=%0d busy=%h want 3/busy4..6", fifo_count, busy); end
    idle();
    rst_n = 0;
    #2;
    model_reset();
    checks++; if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'd0) begin errors++; $display("FAIL rstmid_rf: got %b/%0d/%h want 0/0/0", rf_we, rf_addr, rf_data); end
    checks++; if (busy !== 32'd0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rstmid_state: got busy=%h count=%0d want 0/0", busy, fifo_count); end
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rstmid_post%0d: got we=%b count=%0d want 0/0", i, rf_we, fifo_count); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_fill();
    test_x0();
    test_set_wins();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
